barrier_unit: RTL and testbench
===============================

BARRIER_UNIT -- requirements
Module: barrier_unit

Interface
REQ-001 The block SHALL have the following parameters.
- NUM_CORES, default 4: number of participating cores; legal range 1..32.
- TMO_W, default 16: width of the timeout counter.
- GEN_W, default 8: width of the generation counter.
- AUTO_REARM, default 0: when 1, the barrier re-arms automatically after each release.

REQ-002 The block SHALL have the following ports, clock and reset first.
- clk  in  1: clock; all logic is on the rising edge.
- rst  in  1: reset; asynchronous, active-high.
- arm  in  1: single-cycle request to start a barrier episode.
- mask  in  NUM_CORES: participating cores; sampled only when arm is accepted.
- arrive  in  NUM_CORES: per-core arrival pulses; one or more bits may be set per cycle.
- timeout_cycles  in  TMO_W: timeout in cycles; sampled whenever the block enters GATHER; 0 disables the timeout.
- err_clr  in  1: clears the ERROR state.
- release  out  NUM_CORES: one-cycle release pulse to each participating core.
- done  out  1: one-cycle completion pulse.
- busy  out  1: high while in GATHER, RELEASE or ERROR.
- arrived  out  NUM_CORES: accumulated arrivals for the current episode.
- gen  out  GEN_W: count of completed barrier episodes.
- timeout_err  out  1: high while in ERROR.

Function
REQ-003 The block SHALL implement four states: IDLE, GATHER, RELEASE and ERROR.

REQ-004 IDLE behaviour:
- arm=1 with mask!=0: latch mask into mask_q, clear arrived, load the timeout counter with timeout_cycles, go to GATHER.
- arm=1 with mask==0: no effect.
- arrive: ignored.

REQ-005 GATHER accumulation: each cycle, arrived <= arrived | (arrive & mask_q); arrive bits outside mask_q are ignored; repeated arrivals from the same core have no extra effect.

REQ-006 GATHER completion: when (arrived | (arrive & mask_q)) == mask_q, go to RELEASE on that edge. A single-participant barrier completes on the cycle its arrival is sampled.

REQ-007 RELEASE lasts exactly one cycle:
- release=mask_q and done=1, both combinational from state.
- gen increments by 1 at the end of the cycle, wrapping modulo 2^GEN_W.

REQ-008 Exit from RELEASE when AUTO_REARM=0:
- go to IDLE and clear arrived;
- arrive bits sampled during RELEASE are discarded.

REQ-009 Exit from RELEASE when AUTO_REARM=1:
- return to GATHER with the same mask_q and reload the timeout counter;
- set arrived = arrive & mask_q sampled during the RELEASE cycle, so those arrivals count toward the next episode.

REQ-010 Timeout counter, when timeout_cycles != 0:
- decrements once per GATHER cycle;
- if it reaches 0 without completion, the block enters ERROR;
- therefore ERROR is entered exactly timeout_cycles cycles after GATHER entry.

REQ-011 If completion and timeout expiry occur on the same edge, completion SHALL win and the block goes to RELEASE.

REQ-012 ERROR behaviour:
- timeout_err=1, busy=1, release=0, done=0;
- arrived holds its value for debug, and gen is unchanged;
- err_clr=1 moves the block to IDLE and clears arrived.

REQ-013 arm SHALL be ignored in GATHER, RELEASE and ERROR, and err_clr SHALL be ignored outside ERROR.

REQ-014 arrived, busy and timeout_err SHALL be registered outputs; release and done SHALL be pure decodes of state and mask_q.

Reset
REQ-015 On rst=1, asynchronously:
- state=IDLE;
- mask_q, arrived, gen, the timeout counter, release, done, busy and timeout_err are all 0.

REQ-016 Reset asserted in any state, including mid-GATHER and mid-RELEASE, SHALL abort the episode with no release or done pulse.

Verification
REQ-017 The bench SHALL cover the following directed scenarios (NUM_CORES=4 unless stated):
- Basic barrier: arm with mask=4'b1011; arrive bit 0, then bit 3, then bit 1 on separate cycles -> release=4'b1011 and done=1 for exactly one cycle, one cycle after the bit-1 arrival; gen goes 0->1; busy returns to 0.
- Masking and duplicates: mask=4'b0011; arrive=4'b1100, then 4'b0001 twice -> no release; arrive=4'b0010 -> release=4'b0011 on the next cycle.
- Timeout: timeout_cycles=5, mask=4'b1111, only cores 0-2 arrive -> timeout_err=1 five cycles after GATHER entry; gen unchanged; err_clr -> IDLE with arrived=0.
- Simultaneous completion and expiry: timeout_cycles=3, the last arrival lands on the expiry edge -> release issued and timeout_err stays 0.
- AUTO_REARM=1, NUM_CORES=2, mask=2'b11: after 3 episodes gen=3; an arrival during a RELEASE cycle is counted in the next episode; gen wraps with GEN_W=2 after 4 episodes.
- Reset mid-GATHER with arrived=4'b0101 -> all outputs 0 immediately, no done pulse; a new arm works normally afterwards.

Source files
------------

// File: rtl/barrier_unit.sv
// Multi-core barrier: gathers per-core arrivals against a latched participant mask,
// then issues a one-cycle release, with an optional gather timeout and auto re-arm.
module barrier_unit #(
  parameter int NUM_CORES  = 4,
  parameter int TMO_W      = 16,
  parameter int GEN_W      = 8,
  parameter int AUTO_REARM = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arm,
  input  logic [NUM_CORES-1:0] mask,
  input  logic [NUM_CORES-1:0] arrive,
  input  logic [TMO_W-1:0]     timeout_cycles,
  input  logic                 err_clr,
  // "release" is a reserved word in SystemVerilog, so the release vector is core_release
  output logic [NUM_CORES-1:0] core_release,
  output logic                 done,
  output logic                 busy,
  output logic [NUM_CORES-1:0] arrived,
  output logic [GEN_W-1:0]     gen,
  output logic                 timeout_err
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GATHER  = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;
  localparam logic [1:0] ST_ERROR   = 2'd3;

  logic [1:0]           state_reg, state_next;
  logic [NUM_CORES-1:0] mask_reg, mask_next;
  logic [NUM_CORES-1:0] arrived_reg, arrived_next;
  logic [TMO_W-1:0]     tmo_reg, tmo_next;
  logic [GEN_W-1:0]     gen_reg, gen_next;
  logic                 busy_reg, busy_next;
  logic                 terr_reg, terr_next;
  logic [NUM_CORES-1:0] hit;

  assign hit = arrived_reg | (arrive & mask_reg);

  always_comb begin
    state_next   = state_reg;
    mask_next    = mask_reg;
    arrived_next = arrived_reg;
    tmo_next     = tmo_reg;
    gen_next     = gen_reg;
    case (state_reg)
      ST_IDLE: begin
        if (arm && (mask != '0)) begin
          mask_next    = mask;
          arrived_next = '0;
          tmo_next     = timeout_cycles;
          state_next   = ST_GATHER;
        end
      end
      ST_GATHER: begin
        arrived_next = hit;
        // Completion is tested first so it beats a simultaneous expiry.
        // A zero counter means the timeout is disabled; an armed one never rests at 0 here.
        if (hit == mask_reg) begin
          state_next = ST_RELEASE;
        end else if (tmo_reg == TMO_W'(1)) begin
          tmo_next   = '0;
          state_next = ST_ERROR;
        end else if (tmo_reg != '0) begin
          tmo_next = tmo_reg - TMO_W'(1);
        end
      end
      ST_RELEASE: begin
        gen_next = gen_reg + GEN_W'(1);
        if (AUTO_REARM != 0) begin
          arrived_next = arrive & mask_reg;
          tmo_next     = timeout_cycles;
          state_next   = ST_GATHER;
        end else begin
          arrived_next = '0;
          state_next   = ST_IDLE;
        end
      end
      default: begin
        if (err_clr) begin
          arrived_next = '0;
          state_next   = ST_IDLE;
        end
      end
    endcase
    busy_next = (state_next != ST_IDLE);
    terr_next = (state_next == ST_ERROR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      mask_reg    <= '0;
      arrived_reg <= '0;
      tmo_reg     <= '0;
      gen_reg     <= '0;
      busy_reg    <= 1'b0;
      terr_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      mask_reg    <= mask_next;
      arrived_reg <= arrived_next;
      tmo_reg     <= tmo_next;
      gen_reg     <= gen_next;
      busy_reg    <= busy_next;
      terr_reg    <= terr_next;
    end
  end

  assign done = (state_reg == ST_RELEASE);

  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_rel
    assign core_release[gi] = done & mask_reg[gi];
  end

  assign busy        = busy_reg;
  assign timeout_err = terr_reg;
  assign arrived     = arrived_reg;
  assign gen         = gen_reg;

endmodule

// File: tb/tb_barrier_unit.sv
// Bench for barrier_unit: directed scenarios plus random episodes, checked against
// an arrival-time model of each episode; a second instance covers auto re-arm.
module tb_barrier_unit;

  logic        clk = 1'b0;
  logic        rst;

  logic        arm_a, err_clr_a, done_a, busy_a, terr_a;
  logic [3:0]  mask_a, arrive_a, rel_a, arrived_a;
  logic [15:0] tmo_a;
  logic [7:0]  gen_a;

  logic        arm_b, err_clr_b, done_b, busy_b, terr_b;
  logic [1:0]  mask_b, arrive_b, rel_b, arrived_b;
  logic [15:0] tmo_b;
  logic [1:0]  gen_b;

  int checks = 0;
  int errors = 0;
  int gen_exp_a = 0;
  int gen_exp_b = 0;
  logic [3:0] vecs [0:31];

  always #5 clk = ~clk;

  barrier_unit #(.NUM_CORES(4), .TMO_W(16), .GEN_W(8), .AUTO_REARM(0)) dut_a (
    .clk(clk), .rst(rst), .arm(arm_a), .mask(mask_a), .arrive(arrive_a),
    .timeout_cycles(tmo_a), .err_clr(err_clr_a), .core_release(rel_a), .done(done_a),
    .busy(busy_a), .arrived(arrived_a), .gen(gen_a), .timeout_err(terr_a)
  );

  barrier_unit #(.NUM_CORES(2), .TMO_W(16), .GEN_W(2), .AUTO_REARM(1)) dut_b (
    .clk(clk), .rst(rst), .arm(arm_b), .mask(mask_b), .arrive(arrive_b),
    .timeout_cycles(tmo_b), .err_clr(err_clr_b), .core_release(rel_b), .done(done_b),
    .busy(busy_b), .arrived(arrived_b), .gen(gen_b), .timeout_err(terr_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One episode on dut_a: arm with mask m and timeout t, then apply vecs[0..n-1].
  // The model only tracks the running OR of masked arrivals and the cycle index.
  task automatic run_episode(input logic [3:0] m, input int t, input int n, input bit noise);
    logic [3:0] cum;
    bit         fin;
    cum = 4'b0;
    fin = 1'b0;
    arm_a     = 1'b1;
    mask_a    = m;
    tmo_a     = 16'(t);
    arrive_a  = noise ? 4'($urandom) : 4'b0;
    err_clr_a = noise ? 1'($urandom) : 1'b0;
    tick;
    chk("entry_busy", 32'(busy_a), 1);
    chk("entry_arrived", 32'(arrived_a), 0);
    chk("entry_done", 32'(done_a), 0);
    for (int k = 1; k <= 40 && !fin; k++) begin
      arrive_a  = (k <= n) ? vecs[k-1] : 4'b0;
      arm_a     = noise ? 1'($urandom) : 1'b0;
      mask_a    = noise ? 4'($urandom) : m;
      err_clr_a = noise ? 1'($urandom) : 1'b0;
      if (noise) tmo_a = 16'($urandom_range(1, 3));
      tick;
      cum = cum | (arrive_a & m);
      if (cum == m) begin
        chk("rel_vec", 32'(rel_a), 32'(m));
        chk("rel_done", 32'(done_a), 1);
        chk("rel_busy", 32'(busy_a), 1);
        chk("rel_terr", 32'(terr_a), 0);
        chk("rel_arrived", 32'(arrived_a), 32'(m));
        chk("rel_gen", 32'(gen_a), 32'(gen_exp_a));
        arm_a    = noise ? 1'($urandom) : 1'b0;
        arrive_a = noise ? 4'($urandom) : 4'b0;
        tick;
        gen_exp_a = (gen_exp_a + 1) % 256;
        chk("post_done", 32'(done_a), 0);
        chk("post_rel", 32'(rel_a), 0);
        chk("post_busy", 32'(busy_a), 0);
        chk("post_arrived", 32'(arrived_a), 0);
        chk("post_gen", 32'(gen_a), 32'(gen_exp_a));
        fin = 1'b1;
      end else if (t != 0 && k == t) begin
        chk("err_terr", 32'(terr_a), 1);
        chk("err_busy", 32'(busy_a), 1);
        chk("err_done", 32'(done_a), 0);
        chk("err_rel", 32'(rel_a), 0);
        chk("err_arrived", 32'(arrived_a), 32'(cum));
        chk("err_gen", 32'(gen_a), 32'(gen_exp_a));
        err_clr_a = 1'b0;
        arm_a     = noise ? 1'($urandom) : 1'b0;
        arrive_a  = noise ? 4'($urandom) : 4'b0;
        tick;
        chk("err_hold_terr", 32'(terr_a), 1);
        chk("err_hold_arrived", 32'(arrived_a), 32'(cum));
        err_clr_a = 1'b1;
        tick;
        chk("clr_busy", 32'(busy_a), 0);
        chk("clr_terr", 32'(terr_a), 0);
        chk("clr_arrived", 32'(arrived_a), 0);
        chk("clr_gen", 32'(gen_a), 32'(gen_exp_a));
        fin = 1'b1;
      end else begin
        chk("gat_busy", 32'(busy_a), 1);
        chk("gat_done", 32'(done_a), 0);
        chk("gat_terr", 32'(terr_a), 0);
        chk("gat_arrived", 32'(arrived_a), 32'(cum));
      end
    end
    chk("episode_bound", 32'(fin), 1);
    arm_a     = 1'b0;
    err_clr_a = 1'b0;
    arrive_a  = 4'b0;
  endtask

  initial begin
    logic [3:0] m;
    logic [1:0] a, r, cum_b;
    int n, t;
    bit fin;

    rst = 1'b1;
    arm_a = 1'b0; err_clr_a = 1'b0; mask_a = 4'b0; arrive_a = 4'b0; tmo_a = 16'd0;
    arm_b = 1'b0; err_clr_b = 1'b0; mask_b = 2'b0; arrive_b = 2'b0; tmo_b = 16'd0;
    #12;
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_rel", 32'(rel_a), 0);
    chk("rst_arrived", 32'(arrived_a), 0);
    chk("rst_gen", 32'(gen_a), 0);
    chk("rst_terr", 32'(terr_a), 0);
    chk("rst_b_busy", 32'(busy_b), 0);
    tick;
    rst = 1'b0;

    // arm with an empty mask does nothing
    arm_a = 1'b1; mask_a = 4'b0;
    tick;
    arm_a = 1'b0;
    chk("mask0_busy", 32'(busy_a), 0);
    tick;
    chk("mask0_done", 32'(done_a), 0);

    // basic barrier
    vecs[0] = 4'b0001; vecs[1] = 4'b1000; vecs[2] = 4'b0010;
    run_episode(4'b1011, 0, 3, 1'b0);
    // masking and duplicates
    vecs[0] = 4'b1100; vecs[1] = 4'b0001; vecs[2] = 4'b0001; vecs[3] = 4'b0010;
    run_episode(4'b0011, 0, 4, 1'b0);
    // timeout with core 3 missing
    vecs[0] = 4'b0001; vecs[1] = 4'b0010; vecs[2] = 4'b0100; vecs[3] = 4'b0000; vecs[4] = 4'b0000;
    run_episode(4'b1111, 5, 5, 1'b0);
    // last arrival on the expiry edge
    vecs[0] = 4'b0001; vecs[1] = 4'b0010; vecs[2] = 4'b1100;
    run_episode(4'b1111, 3, 3, 1'b0);

    for (int ep = 0; ep < 25; ep++) begin
      m = 4'($urandom_range(1, 15));
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) vecs[i] = 4'($urandom) & 4'($urandom);
      vecs[n-1] = vecs[n-1] | m;
      t = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, n + 1);
      run_episode(m, t, n, 1'b1);
    end

    // reset mid-GATHER
    arm_a = 1'b1; mask_a = 4'b1111; tmo_a = 16'd0;
    tick;
    arm_a = 1'b0; arrive_a = 4'b0101;
    tick;
    chk("mid_arrived", 32'(arrived_a), 32'h5);
    arrive_a = 4'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy_a), 0);
    chk("mid_rst_arrived", 32'(arrived_a), 0);
    chk("mid_rst_done", 32'(done_a), 0);
    chk("mid_rst_rel", 32'(rel_a), 0);
    chk("mid_rst_gen", 32'(gen_a), 0);
    chk("mid_rst_terr", 32'(terr_a), 0);
    gen_exp_a = 0;
    tick;
    chk("mid_rst_done2", 32'(done_a), 0);
    rst = 1'b0;
    vecs[0] = 4'b0110; vecs[1] = 4'b0001;
    run_episode(4'b0111, 4, 2, 1'b0);

    // auto re-arm instance
    arm_b = 1'b1; mask_b = 2'b11; tmo_b = 16'd0;
    tick;
    arm_b = 1'b0;
    chk("b_entry_busy", 32'(busy_b), 1);
    cum_b = 2'b00;
    gen_exp_b = 0;
    for (int e = 0; e < 6; e++) begin
      fin = 1'b0;
      for (int k = 1; k <= 20 && !fin; k++) begin
        if (e == 0) a = (k == 1) ? 2'b01 : 2'b10;
        else if (e == 1) a = 2'b10;
        else a = (k == 20) ? 2'b11 : 2'($urandom);
        arrive_b = a;
        tick;
        cum_b = cum_b | a;
        if (cum_b == 2'b11) begin
          chk("b_rel_done", 32'(done_b), 1);
          chk("b_rel_vec", 32'(rel_b), 3);
          chk("b_rel_gen", 32'(gen_b), 32'(gen_exp_b));
          r = (e == 0) ? 2'b01 : 2'($urandom);
          arrive_b = r;
          tick;
          gen_exp_b = (gen_exp_b + 1) % 4;
          chk("b_post_gen", 32'(gen_b), 32'(gen_exp_b));
          chk("b_post_done", 32'(done_b), 0);
          chk("b_post_busy", 32'(busy_b), 1);
          chk("b_post_arrived", 32'(arrived_b), 32'(r));
          cum_b = r;
          fin = 1'b1;
        end else begin
          chk("b_gat_arrived", 32'(arrived_b), 32'(cum_b));
          chk("b_gat_done", 32'(done_b), 0);
        end
      end
      chk("b_episode_bound", 32'(fin), 1);
    end
    arrive_b = 2'b00;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
